// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// hands fetched words (or NOP bubbles) to the IF/ID register.
module pipeline_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_tag,
   input  logic [31:0] branch_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_t;

   state_t      r_state;
   state_t      w_state_n;

   logic [31:0] r_pc;
   logic        r_req;
   logic [31:0] r_addr;
   logic [31:0] r_inst;
   logic [31:0] r_pco;
   logic        r_vld;
   logic [31:0] r_bi;
   logic [31:0] r_bp;

   logic [31:0] w_pc_n;
   logic        w_req_n;
   logic [31:0] w_addr_n;
   logic [31:0] w_inst_n;
   logic [31:0] w_pco_n;
   logic        w_vld_n;
   logic [31:0] w_bi_n;
   logic [31:0] w_bp_n;

   logic [31:0] w_tgt;
   logic [31:0] w_inc;

   assign w_tgt = {branch_addr[31:2], 2'b00};
   assign w_inc = r_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   // A redirect with a response still in flight must swallow that response.
   always_comb begin
      w_state_n = r_state;
      if (branch_tag) begin
         if ((r_state == S_WAIT || r_state == S_DROP) && !imem_rvalid)
            w_state_n = S_DROP;
         else
            w_state_n = S_WAIT;
      end else begin
         unique case (r_state)
            S_IDLE: w_state_n = S_WAIT;
            S_WAIT: if (imem_rvalid && stall) w_state_n = S_HOLD;
            S_HOLD: if (!stall) w_state_n = S_WAIT;
            S_DROP: if (imem_rvalid) w_state_n = S_WAIT;
         endcase
      end
   end

   always_comb begin
      w_pc_n   = r_pc;
      w_req_n  = 1'b0;
      w_addr_n = r_addr;
      w_inst_n = stall ? r_inst : NOP_INST;
      w_pco_n  = r_pco;
      w_vld_n  = stall ? r_vld : 1'b0;
      w_bi_n   = r_bi;
      w_bp_n   = r_bp;
      if (branch_tag) begin
         w_pc_n   = w_tgt;
         w_bi_n   = '0;
         w_bp_n   = '0;
         w_inst_n = NOP_INST;
         w_vld_n  = 1'b0;
         if (w_state_n == S_WAIT) begin
            w_req_n  = 1'b1;
            w_addr_n = w_tgt;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_req_n  = 1'b1;
               w_addr_n = r_pc;
            end
            S_WAIT: begin
               if (imem_rvalid && !stall) begin
                  w_inst_n = imem_rdata;
                  w_pco_n  = r_pc;
                  w_vld_n  = 1'b1;
                  w_pc_n   = w_inc;
                  w_req_n  = 1'b1;
                  w_addr_n = w_inc;
               end else if (imem_rvalid) begin
                  w_bi_n = imem_rdata;
                  w_bp_n = r_pc;
                  w_pc_n = w_inc;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  w_inst_n = r_bi;
                  w_pco_n  = r_bp;
                  w_vld_n  = 1'b1;
                  w_req_n  = 1'b1;
                  w_addr_n = r_pc;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  w_req_n  = 1'b1;
                  w_addr_n = r_pc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc   <= RESET_PC;
         r_req  <= 1'b0;
         r_addr <= RESET_PC;
         r_inst <= NOP_INST;
         r_pco  <= '0;
         r_vld  <= 1'b0;
         r_bi   <= '0;
         r_bp   <= '0;
      end else begin
         r_pc   <= w_pc_n;
         r_req  <= w_req_n;
         r_addr <= w_addr_n;
         r_inst <= w_inst_n;
         r_pco  <= w_pco_n;
         r_vld  <= w_vld_n;
         r_bi   <= w_bi_n;
         r_bp   <= w_bp_n;
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign inst       = r_inst;
   assign pc         = r_pco;
   assign inst_valid = r_vld;

endmodule
